// File: rtl/morse_letter_assembler_if.sv
// Key-pulse inputs and letter-offer outputs of morse_letter_assembler.
// The assembler uses the slave modport. The key front end and the decoder drive the master modport.
interface morse_letter_assembler_if #(
  parameter int MAX_LEN = 5
);
  // Handshake rules:
  //   - A letter transfers on a rising edge where code_valid and out_ready are both high.
  //   - While code_valid is high, code, code_len and overflow stay constant.
  //   - code_valid does not wait for out_ready, and it does not drop until the transfer.
  //   - out_ready may change at any time and has no effect while code_valid is low.
  logic               ld_dot;
  logic               ld_line;
  logic               tick;
  logic               out_ready;
  logic [MAX_LEN-1:0] code;
  logic [2:0]         code_len;
  logic               code_valid;
  logic               overflow;

  modport slave (
    input  ld_dot, ld_line, tick, out_ready,
    output code, code_len, code_valid, overflow
  );

  modport master (
    output ld_dot, ld_line, tick, out_ready,
    input  code, code_len, code_valid, overflow
  );
endinterface

// File: rtl/morse_letter_assembler.sv
// Collects dot/line pulses into a letter code, closes it after GAP_TICKS silent ticks, and offers it on valid/ready.
// Defining MORSE_HOLD_CAPTURE_EN keeps the first symbol keyed while a letter waits, as the start of the next letter.
module morse_letter_assembler #(
  parameter int MAX_LEN   = 5,
  parameter int GAP_TICKS = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  morse_letter_assembler_if.slave     bus,
  output logic [1:0]                  o_dbg_state
);
  localparam int GW = $clog2(GAP_TICKS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]         r_state;
  logic [MAX_LEN-1:0] r_code;
  logic [2:0]         r_len;
  logic [GW-1:0]      r_gap;
  logic               r_ovf;

  logic w_evt;
  logic w_sym;
  logic w_full;
  logic w_gap_done;
  logic w_xfer;

  // A simultaneous dot and line counts as a line.
  assign w_evt      = bus.ld_dot | bus.ld_line;
  assign w_sym      = bus.ld_line;
  assign w_full     = (r_len == 3'(MAX_LEN));
  assign w_gap_done = bus.tick && (r_gap == GW'(GAP_TICKS - 1));
  assign w_xfer     = (r_state == S_HOLD) && bus.out_ready;

`ifdef MORSE_HOLD_CAPTURE_EN
  logic r_skid_full;
  logic r_skid_sym;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_len   <= '0;
      r_gap   <= '0;
      r_ovf   <= 1'b0;
`ifdef MORSE_HOLD_CAPTURE_EN
      r_skid_full <= 1'b0;
      r_skid_sym  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_evt) begin
            r_code  <= MAX_LEN'(w_sym);
            r_len   <= 3'd1;
            r_gap   <= '0;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_evt) begin
            r_gap <= '0;
            if (!w_full) begin
              r_code <= {r_code[MAX_LEN-2:0], w_sym};
              r_len  <= r_len + 3'd1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (bus.tick) begin
            // The counter stops at GAP_TICKS because the state leaves S_COLLECT on the same edge.
            r_gap <= r_gap + GW'(1);
            if (w_gap_done) r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
`ifdef MORSE_HOLD_CAPTURE_EN
          if (w_xfer) begin
            r_ovf       <= 1'b0;
            r_gap       <= '0;
            r_skid_full <= 1'b0;
            // A symbol on the transfer edge itself still counts as the first one keyed during the hold.
            if (r_skid_full || w_evt) begin
              r_code  <= MAX_LEN'(r_skid_full ? r_skid_sym : w_sym);
              r_len   <= 3'd1;
              r_state <= S_COLLECT;
            end else begin
              r_code  <= '0;
              r_len   <= '0;
              r_state <= S_IDLE;
            end
          end else if (w_evt && !r_skid_full) begin
            r_skid_full <= 1'b1;
            r_skid_sym  <= w_sym;
          end
`else
          if (w_xfer) begin
            r_code  <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            r_gap   <= '0;
            r_state <= S_IDLE;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.code       = r_code;
  assign bus.code_len   = r_len;
  assign bus.overflow   = r_ovf;
  assign bus.code_valid = (r_state == S_HOLD);
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_morse_letter_assembler.sv
// Directed bench for morse_letter_assembler: a transfer monitor checks letters against a queue, and inline checks cover timing and reset.
module tb_morse_letter_assembler;
  localparam int W = 9;  // {overflow, code_len[2:0], code[4:0]}

  logic       clock;
  logic       resetn;
  logic [1:0] dbg_state;

  morse_letter_assembler_if #(.MAX_LEN(5)) bus ();

  morse_letter_assembler #(.MAX_LEN(5), .GAP_TICKS(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] pack(input logic ovf, input logic [2:0] len, input logic [4:0] code);
    return {ovf, len, code};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge and are sampled on the next one
  task automatic drive(input logic dot, input logic line, input logic tk);
    bus.ld_dot  = dot;
    bus.ld_line = line;
    bus.tick    = tk;
    @(posedge clock); #1;
    bus.ld_dot  = 1'b0;
    bus.ld_line = 1'b0;
    bus.tick    = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic xfer();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  // scoreboard monitor: a transfer happens on the edge that follows this sample
  always @(negedge clock) begin
    if (resetn && bus.code_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected no letter at %0t",
                 {bus.overflow, bus.code_len, bus.code}, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.overflow, bus.code_len, bus.code} !== e) begin
          n_err++;
          $display("FAIL sb_letter: got %0h expected %0h at %0t",
                   {bus.overflow, bus.code_len, bus.code}, e, $time);
        end
      end
    end
  end

  initial begin
    bus.ld_dot = 1'b0; bus.ld_line = 1'b0; bus.tick = 1'b0; bus.out_ready = 1'b0;
    resetn = 1'b0;
    idle_cycles(3);
    chk("rst_valid", 32'(bus.code_valid), 32'd0);
    chk("rst_code",  32'(bus.code),       32'd0);
    chk("rst_len",   32'(bus.code_len),   32'd0);
    chk("rst_ovf",   32'(bus.overflow),   32'd0);
    chk("rst_state", 32'(dbg_state),      32'd0);
    resetn = 1'b1;
    idle_cycles(2);

    // 1: letter A, then a single-cycle transfer
    drive(1'b1, 1'b0, 1'b0);
    chk("a_first_sym", 32'({bus.code_len, bus.code}), 32'({3'd1, 5'b00000}));
    drive(1'b0, 1'b1, 1'b0);
    ticks(7);
    chk("a_valid_early", 32'(bus.code_valid), 32'd0);
    ticks(1);
    chk("a_valid", 32'(bus.code_valid), 32'd1);
    chk("a_code",  32'(bus.code),       32'd1);
    chk("a_len",   32'(bus.code_len),   32'd2);
    exp_q.push_back(pack(1'b0, 3'd2, 5'b00001));
    xfer();
    chk("a_valid_fall", 32'(bus.code_valid), 32'd0);
    chk("a_cleared", 32'({bus.code_len, bus.code}), 32'd0);

    // 2: a symbol restarts the gap count
    drive(1'b1, 1'b0, 1'b0);
    ticks(7);
    drive(1'b0, 1'b1, 1'b0);
    ticks(7);
    chk("gap_valid_early", 32'(bus.code_valid), 32'd0);
    ticks(1);
    chk("gap_valid", 32'(bus.code_valid), 32'd1);
    chk("gap_letter", 32'({bus.code_len, bus.code}), 32'({3'd2, 5'b00001}));
    exp_q.push_back(pack(1'b0, 3'd2, 5'b00001));
    xfer();

    // 3: overflow is sticky and clears on transfer
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0);
    chk("ovf_not_yet", 32'(bus.overflow), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    ticks(8);
    chk("ovf_letter", 32'({bus.overflow, bus.code_len, bus.code}), 32'({1'b1, 3'd5, 5'b11111}));
    exp_q.push_back(pack(1'b1, 3'd5, 5'b11111));
    xfer();
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // 4: backpressure keeps the letter stable
    drive(1'b1, 1'b0, 1'b0);
    ticks(8);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b0, 1'b1);
      else idle_cycles(1);
      chk("bp_stable", 32'({bus.code_valid, bus.code_len, bus.code}), 32'({1'b1, 3'd1, 5'b00000}));
    end
    exp_q.push_back(pack(1'b0, 3'd1, 5'b00000));
    xfer();
    chk("bp_done", 32'(bus.code_valid), 32'd0);

    // 5: symbols keyed while a letter is held
    drive(1'b1, 1'b0, 1'b0);
    ticks(8);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("hc_held", 32'({bus.code_len, bus.code}), 32'({3'd1, 5'b00000}));
    exp_q.push_back(pack(1'b0, 3'd1, 5'b00000));
    xfer();
`ifdef MORSE_HOLD_CAPTURE_EN
    chk("hc_state", 32'(dbg_state), 32'd1);
    chk("hc_code",  32'(bus.code), 32'd1);
    chk("hc_len",   32'(bus.code_len), 32'd1);
    ticks(8);
    exp_q.push_back(pack(1'b0, 3'd1, 5'b00001));
    xfer();
`else
    chk("hc_state", 32'(dbg_state), 32'd0);
    chk("hc_len",   32'(bus.code_len), 32'd0);
`endif

    // 6: asynchronous reset mid-letter
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("mr_before", 32'(bus.code_len), 32'd2);
    #2 resetn = 1'b0;
    #1;
    chk("mr_outputs", 32'({bus.code_valid, bus.overflow, bus.code_len, bus.code}), 32'd0);
    chk("mr_state", 32'(dbg_state), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    ticks(8);
    chk("mr_letter", 32'({bus.code_len, bus.code}), 32'({3'd1, 5'b00001}));
    exp_q.push_back(pack(1'b0, 3'd1, 5'b00001));
    xfer();

    // 7: dot+line counts as a line, a symbol beats a tick, and ready is already high when the letter closes
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    ticks(7);
    drive(1'b1, 1'b0, 1'b1);
    ticks(7);
    chk("st_valid_early", 32'(bus.code_valid), 32'd0);
    exp_q.push_back(pack(1'b0, 3'd2, 5'b00010));
    ticks(1);
    chk("st_valid", 32'(bus.code_valid), 32'd1);
    idle_cycles(1);
    chk("st_min_hs", 32'(bus.code_valid), 32'd0);
    bus.out_ready = 1'b0;

    idle_cycles(2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
